// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: state encoding, bus
// width and reset value of the data path.
package dmem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_SECOND = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_e;

    localparam int          DATA_BUS     = 32;
    localparam logic [31:0] DATA_INITIAL = 32'h0000_0000;

    // Byte strobes only reach the memory for stores.
    function automatic logic [3:0] strobe_gate(input logic we, input logic [3:0] wea);
        return we ? wea : 4'b0000;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter.sv
// Shares one asynchronous-read data-memory port between two memory-stage lanes,
// serialising same-cycle accesses in program order with a one-cycle stall.
//
// state      | meaning
// ARB_IDLE   | single access passes through; dual access serves older lane
// ARB_SECOND | younger lane served, older result replayed from hold_old
// ARB_DONE   | pair complete but pipeline frozen; replay both results, no access
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int DW = DATA_BUS,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ext_stop_i,
    input  logic          older_i,
    input  logic          req0_i,
    input  logic          req1_i,
    input  logic          we0_i,
    input  logic          we1_i,
    input  logic [3:0]    wea0_i,
    input  logic [3:0]    wea1_i,
    input  logic [DW-1:0] addr0_i,
    input  logic [DW-1:0] addr1_i,
    input  logic [DW-1:0] wdata0_i,
    input  logic [DW-1:0] wdata1_i,
    output logic [DW-1:0] rdata0_o,
    output logic [DW-1:0] rdata1_o,
    output logic          stall_o,
    output logic          mem_w_o,
    output logic [3:0]    mem_wea_o,
    output logic [DW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic [CW-1:0] conflict_cnt_o
);

    arb_state_e    state_q, state_d;
    logic          ord_q, ord_d;
    logic [DW-1:0] hold_old_q, hold_old_d;
    logic [DW-1:0] hold_yng_q, hold_yng_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          sel_valid;
    logic          sel_lane;
    logic          yng_req;
    logic [DW-1:0] old_rd;
    logic [DW-1:0] yng_rd;
    logic          we_sel;
    logic [3:0]    wea_sel;

    always_comb begin
        state_d    = state_q;
        ord_d      = ord_q;
        hold_old_d = hold_old_q;
        hold_yng_d = hold_yng_q;
        cnt_d      = cnt_q;
        sel_valid  = 1'b0;
        sel_lane   = 1'b0;
        stall_o    = 1'b0;
        rdata0_o   = '0;
        rdata1_o   = '0;
        old_rd     = '0;
        yng_rd     = '0;
        yng_req    = ord_q ? req0_i : req1_i;

        unique case (state_q)
            ARB_IDLE: begin
                if (req0_i && req1_i) begin
                    sel_valid  = 1'b1;
                    sel_lane   = older_i;
                    stall_o    = 1'b1;
                    ord_d      = older_i;
                    hold_old_d = mem_rdata_i;
                    cnt_d      = cnt_q + 1'b1;
                    state_d    = ARB_SECOND;
                    if (older_i) rdata1_o = mem_rdata_i;
                    else         rdata0_o = mem_rdata_i;
                end else if (req0_i) begin
                    sel_valid = 1'b1;
                    sel_lane  = 1'b0;
                    rdata0_o  = mem_rdata_i;
                end else if (req1_i) begin
                    sel_valid = 1'b1;
                    sel_lane  = 1'b1;
                    rdata1_o  = mem_rdata_i;
                end
            end
            ARB_SECOND: begin
                // A reset landing here aborts the pair before the younger access.
                if (yng_req && !rst) begin
                    sel_valid = 1'b1;
                    sel_lane  = ~ord_q;
                    yng_rd    = mem_rdata_i;
                end
                old_rd     = hold_old_q;
                hold_yng_d = yng_rd;
                state_d    = ext_stop_i ? ARB_DONE : ARB_IDLE;
            end
            default: begin
                old_rd = hold_old_q;
                yng_rd = hold_yng_q;
                if (!ext_stop_i) state_d = ARB_IDLE;
            end
        endcase

        if (state_q != ARB_IDLE) begin
            rdata0_o = ord_q ? yng_rd : old_rd;
            rdata1_o = ord_q ? old_rd : yng_rd;
        end
    end

    assign we_sel         = sel_lane ? we1_i : we0_i;
    assign wea_sel        = sel_lane ? wea1_i : wea0_i;
    assign mem_w_o        = sel_valid & we_sel;
    assign mem_wea_o      = sel_valid ? strobe_gate(we_sel, wea_sel) : 4'b0000;
    assign mem_addr_o     = sel_valid ? (sel_lane ? addr1_i : addr0_i) : '0;
    assign mem_wdata_o    = sel_valid ? (sel_lane ? wdata1_i : wdata0_i) : '0;
    assign conflict_cnt_o = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            ord_q      <= 1'b0;
            hold_old_q <= DW'(DATA_INITIAL);
            hold_yng_q <= DW'(DATA_INITIAL);
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ord_q      <= ord_d;
            hold_old_q <= hold_old_d;
            hold_yng_q <= hold_yng_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter against a small word-addressed memory
// model with asynchronous read; expected values are hand-computed constants.
module tb_dmem_port_arbiter;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ext_stop, older, req0, req1, we0, we1;
    logic [3:0]    wea0, wea1;
    logic [DW-1:0] addr0, addr1, wdata0, wdata1;
    logic [DW-1:0] rdata0, rdata1;
    logic          stall, mem_w;
    logic [3:0]    mem_wea;
    logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
    logic [CW-1:0] conflict_cnt;

    logic [31:0]   mem [0:255];
    logic          bd_we;
    logic [7:0]    bd_idx;
    logic [31:0]   bd_data;
    logic          wr_clr;
    int            wr_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.DW(DW), .CW(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .ext_stop_i     (ext_stop),
        .older_i        (older),
        .req0_i         (req0),
        .req1_i         (req1),
        .we0_i          (we0),
        .we1_i          (we1),
        .wea0_i         (wea0),
        .wea1_i         (wea1),
        .addr0_i        (addr0),
        .addr1_i        (addr1),
        .wdata0_i       (wdata0),
        .wdata1_i       (wdata1),
        .rdata0_o       (rdata0),
        .rdata1_o       (rdata1),
        .stall_o        (stall),
        .mem_w_o        (mem_w),
        .mem_wea_o      (mem_wea),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata),
        .conflict_cnt_o (conflict_cnt)
    );

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_idx] <= bd_data;
        end else if (mem_w) begin
            for (int b = 0; b < 4; b++)
                if (mem_wea[b]) mem[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
        if (wr_clr)     wr_cnt <= 0;
        else if (mem_w) wr_cnt <= wr_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [7:0] idx, input logic [31:0] data);
        bd_we = 1'b1; bd_idx = idx; bd_data = data;
        tick();
        bd_we = 1'b0;
    endtask

    task automatic idle_lanes();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; wea0 = 0; wea1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; older = 0; ext_stop = 0;
    endtask

    task automatic lane0(input logic we, input logic [31:0] a, input logic [31:0] d);
        req0 = 1; we0 = we; wea0 = we ? 4'hF : 4'h0; addr0 = a; wdata0 = d;
    endtask

    task automatic lane1(input logic we, input logic [31:0] a, input logic [31:0] d);
        req1 = 1; we1 = we; wea1 = we ? 4'hF : 4'h0; addr1 = a; wdata1 = d;
    endtask

    initial begin
        idle_lanes();
        rst = 1; bd_we = 0; bd_idx = 0; bd_data = 0; wr_clr = 1;
        tick(); tick();
        rst = 0; wr_clr = 0;
        poke(8'h40, 32'hDEADBEEF);
        poke(8'h10, 32'h0BADF00D);
        poke(8'h30, 32'h12345678);

        // reset state
        @(negedge clk);
        check_eq("rst_stall",   {31'd0, stall}, 0);
        check_eq("rst_mem_w",   {31'd0, mem_w}, 0);
        check_eq("rst_wea",     {28'd0, mem_wea}, 0);
        check_eq("rst_addr",    mem_addr, 0);
        check_eq("rst_wdata",   mem_wdata, 0);
        check_eq("rst_rdata0",  rdata0, 0);
        check_eq("rst_rdata1",  rdata1, 0);
        check_eq("rst_cnt",     {28'd0, conflict_cnt}, 0);
        tick();

        // single load on lane1
        lane1(0, 32'h100, 0);
        @(negedge clk);
        check_eq("single_addr",   mem_addr, 32'h100);
        check_eq("single_rdata1", rdata1, 32'hDEADBEEF);
        check_eq("single_rdata0", rdata0, 0);
        check_eq("single_stall",  {31'd0, stall}, 0);
        check_eq("single_cnt",    {28'd0, conflict_cnt}, 0);
        tick();
        idle_lanes();

        // dual: lane1 older store, lane0 younger load, same word
        older = 1;
        lane1(1, 32'h40, 32'h11223344);
        lane0(0, 32'h40, 0);
        @(negedge clk);
        check_eq("d1_n_mem_w",  {31'd0, mem_w}, 1);
        check_eq("d1_n_stall",  {31'd0, stall}, 1);
        check_eq("d1_n_wea",    {28'd0, mem_wea}, 32'hF);
        check_eq("d1_n_wdata",  mem_wdata, 32'h11223344);
        check_eq("d1_n_rdata1", rdata1, 32'h0BADF00D);
        tick();
        @(negedge clk);
        check_eq("d1_n1_mem_w",  {31'd0, mem_w}, 0);
        check_eq("d1_n1_stall",  {31'd0, stall}, 0);
        check_eq("d1_n1_rdata0", rdata0, 32'h11223344);
        check_eq("d1_n1_rdata1", rdata1, 32'h0BADF00D);
        check_eq("d1_cnt",       {28'd0, conflict_cnt}, 1);
        tick();
        idle_lanes();
        poke(8'h10, 32'hAAAA5555);

        // dual: lane0 older load, lane1 younger store of zero
        older = 0;
        lane0(0, 32'h40, 0);
        lane1(1, 32'h40, 32'h0);
        @(negedge clk);
        check_eq("d2_n_stall",  {31'd0, stall}, 1);
        check_eq("d2_n_mem_w",  {31'd0, mem_w}, 0);
        check_eq("d2_n_rdata0", rdata0, 32'hAAAA5555);
        tick();
        @(negedge clk);
        check_eq("d2_n1_mem_w",  {31'd0, mem_w}, 1);
        check_eq("d2_n1_rdata0", rdata0, 32'hAAAA5555);
        check_eq("d2_n1_stall",  {31'd0, stall}, 0);
        tick();
        idle_lanes();
        @(negedge clk);
        check_eq("d2_mem",  mem[8'h10], 0);
        check_eq("d2_cnt",  {28'd0, conflict_cnt}, 2);
        check_eq("d2_idle_rdata0", rdata0, 0);
        tick();

        // dual store/store with ext_stop held three cycles after the pair starts
        wr_clr = 1; tick(); wr_clr = 0;
        older = 0;
        lane0(1, 32'h80, 32'h1);
        lane1(1, 32'h80, 32'h2);
        @(negedge clk);
        check_eq("es_n_wdata", mem_wdata, 32'h1);
        tick();
        ext_stop = 1;
        @(negedge clk);
        check_eq("es_n1_wdata", mem_wdata, 32'h2);
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) ext_stop = 0;
            @(negedge clk);
            check_eq("es_done_mem_w", {31'd0, mem_w}, 0);
            check_eq("es_done_wea",   {28'd0, mem_wea}, 0);
            check_eq("es_done_stall", {31'd0, stall}, 0);
            tick();
        end
        idle_lanes();
        @(negedge clk);
        check_eq("es_writes", wr_cnt, 2);
        check_eq("es_mem",    mem[8'h20], 32'h2);
        check_eq("es_cnt",    {28'd0, conflict_cnt}, 3);
        tick();

        // reset while the younger store is pending
        wr_clr = 1; tick(); wr_clr = 0;
        older = 0;
        lane0(0, 32'hC0, 0);
        lane1(1, 32'hC0, 32'h55);
        @(negedge clk);
        check_eq("ra_n_stall", {31'd0, stall}, 1);
        tick();
        rst = 1;
        @(negedge clk);
        check_eq("ra_cnt_pre", {28'd0, conflict_cnt}, 4);
        check_eq("ra_mem_w",   {31'd0, mem_w}, 0);
        tick();
        rst = 0;
        idle_lanes();
        @(negedge clk);
        check_eq("ra_stall",  {31'd0, stall}, 0);
        check_eq("ra_rdata0", rdata0, 0);
        check_eq("ra_rdata1", rdata1, 0);
        check_eq("ra_cnt",    {28'd0, conflict_cnt}, 0);
        check_eq("ra_writes", wr_cnt, 0);
        check_eq("ra_mem",    mem[8'hC0 >> 2], 32'h12345678);
        tick();

        // counter wrap: 15 back-to-back dual loads, then one more
        lane0(0, 32'h100, 0);
        lane1(0, 32'h100, 0);
        for (int i = 0; i < 30; i++) tick();
        @(negedge clk);
        check_eq("wrap_15", {28'd0, conflict_cnt}, 15);
        tick();
        @(negedge clk);
        check_eq("wrap_0", {28'd0, conflict_cnt}, 0);
        check_eq("wrap_second_rdata0", rdata0, 32'hDEADBEEF);
        tick();
        idle_lanes();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
